// File: rtl/segment_scan.sv
// Two-digit multiplexed 7-segment driver: snapshots both digit patterns once per frame,
// lights tens then units with an optional blanking gap after each; all outputs registered.
module segment_scan #(
  parameter int DIV            = 50000,
  parameter int BLANK          = 500,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] seg1,
  input  logic [8:0] seg2,
  output logic [7:0] seg_out,
  output logic [1:0] dig_en,
  output logic       frame_tick
);

  typedef enum logic [1:0] {SHOW1, GAP1, SHOW0, GAP0} state_t;

  localparam int MAXL = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  // With no gap, GAP0 is only ever the reset state and must exit on the first edge.
  localparam logic [CW-1:0] BLANK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic [7:0]    SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [1:0]    DIG_OFF    = (DIG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [8:0]      snap1_q, snap1_d;
  logic [8:0]      snap2_q, snap2_d;
  logic [7:0]      seg_out_q, seg_out_d;
  logic [1:0]      dig_en_q, dig_en_d;
  logic            frame_tick_q, frame_tick_d;
  logic            last;
  logic            enter_show1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= GAP0;
      cnt_q        <= BLANK_LAST;
      snap1_q      <= '0;
      snap2_q      <= '0;
      seg_out_q    <= SEG_OFF;
      dig_en_q     <= DIG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      snap1_q      <= snap1_d;
      snap2_q      <= snap2_d;
      seg_out_q    <= seg_out_d;
      dig_en_q     <= dig_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    snap1_d = snap1_q;
    snap2_d = snap2_q;
    case (state_q)
      SHOW1, SHOW0: last = (cnt_q == DIV_LAST);
      default:      last = (cnt_q == BLANK_LAST);
    endcase
    if (last) begin
      cnt_d = '0;
      case (state_q)
        SHOW1:   state_d = (BLANK > 0) ? GAP1 : SHOW0;
        GAP1:    state_d = SHOW0;
        SHOW0:   state_d = (BLANK > 0) ? GAP0 : SHOW1;
        default: state_d = SHOW1;
      endcase
    end
    // Both digits are captured together so a frame never mixes two notes.
    enter_show1 = (state_d == SHOW1) && (state_q != SHOW1);
    if (enter_show1) begin
      snap1_d = seg1;
      snap2_d = seg2;
    end
  end

  always_comb begin
    seg_out_d    = SEG_OFF;
    dig_en_d     = DIG_OFF;
    frame_tick_d = enter_show1;
    case (state_d)
      SHOW1: if (snap1_d != 9'h000) begin
        seg_out_d = snap1_d[7:0] ^ SEG_OFF;
        dig_en_d  = 2'b10 ^ DIG_OFF;
      end
      SHOW0: if (snap2_d != 9'h000) begin
        seg_out_d = snap2_d[7:0] ^ SEG_OFF;
        dig_en_d  = 2'b01 ^ DIG_OFF;
      end
      default: ;
    endcase
  end

  assign seg_out    = seg_out_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = frame_tick_q;

endmodule
